// File: rtl/tone_buffer.sv
// Ping-pong DMT symbol buffer: captures (carrier, X, Y) in tone order and
// replays each completed symbol in ascending carrier order over valid/ready.
module tone_buffer #(
  parameter int CNUMW  = 8,
  parameter int CONSTW = 16,
  parameter int NCARR  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              xy_ready_i,
  input  logic [CNUMW-1:0]  carrier_num_i,
  input  logic [CONSTW-1:0] x_i,
  input  logic [CONSTW-1:0] y_i,
  input  logic [CNUMW:0]    used_c_i,
  output logic              wr_ready_o,
  output logic              overflow_o,
  output logic              valid_o,
  input  logic              ifft_ready_i,
  output logic [CNUMW-1:0]  idx_o,
  output logic [CONSTW-1:0] re_o,
  output logic [CONSTW-1:0] im_o,
  output logic              last_o
);

  localparam logic [CNUMW:0]   FULL_CNT = (CNUMW+1)'(NCARR);
  localparam logic [CNUMW-1:0] LAST_IDX = CNUMW'(NCARR - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [CONSTW-1:0] mem_x [2][NCARR];
  logic [CONSTW-1:0] mem_y [2][NCARR];
  logic [NCARR-1:0]  flag  [2];
  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [CNUMW:0]    cnt;
  logic [CNUMW:0]    limit;
  logic [CNUMW:0]    cnt_inc;
  logic [CNUMW:0]    eff_limit;
  logic              wr_fire;

  state_t            state;
  state_t            state_next;
  logic [CNUMW-1:0]  rd_idx;
  logic [CNUMW-1:0]  load_idx;
  logic              load;
  logic              accept;
  logic              release_bank;

  assign wr_ready_o = !full[wr_bank];
  assign wr_fire    = xy_ready_i && wr_ready_o;
  assign cnt_inc    = cnt + (CNUMW+1)'(1);
  assign idx_o      = rd_idx;
  assign last_o     = valid_o && (rd_idx == LAST_IDX);

  // The symbol length is sampled on its first write; later used_c_i changes are ignored.
  always_comb begin
    eff_limit = limit;
    if (cnt == '0) eff_limit = (used_c_i == '0) ? FULL_CNT : used_c_i;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_x[wr_bank][carrier_num_i] <= x_i;
      mem_y[wr_bank][carrier_num_i] <= y_i;
    end
  end

  // Write and read sides never touch the same bank's full bit or flags in one
  // edge: writes need a non-full bank, reads only release a full one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag[0]    <= '0;
      flag[1]    <= '0;
      full       <= '0;
      wr_bank    <= 1'b0;
      cnt        <= '0;
      limit      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (xy_ready_i && !wr_ready_o) overflow_o <= 1'b1;
      if (accept) flag[rd_bank][rd_idx] <= 1'b0;
      if (release_bank) full[rd_bank] <= 1'b0;
      if (wr_fire) begin
        flag[wr_bank][carrier_num_i] <= 1'b1;
        limit <= eff_limit;
        if (cnt_inc == eff_limit) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          cnt           <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    load         = 1'b0;
    load_idx     = rd_idx;
    accept       = 1'b0;
    release_bank = 1'b0;
    unique case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          load       = 1'b1;
          load_idx   = '0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (ifft_ready_i) begin
          accept = 1'b1;
          if (rd_idx != LAST_IDX) begin
            load     = 1'b1;
            load_idx = rd_idx + CNUMW'(1);
          end else begin
            release_bank = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_o <= 1'b0;
      rd_idx  <= '0;
      re_o    <= '0;
      im_o    <= '0;
      rd_bank <= 1'b0;
    end else begin
      if (load) begin
        valid_o <= 1'b1;
        rd_idx  <= load_idx;
        re_o    <= flag[rd_bank][load_idx] ? mem_x[rd_bank][load_idx] : '0;
        im_o    <= flag[rd_bank][load_idx] ? mem_y[rd_bank][load_idx] : '0;
      end
      if (release_bank) begin
        valid_o <= 1'b0;
        rd_bank <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_tone_buffer.sv
// Directed bench for tone_buffer: fill/readout, backpressure, ping-pong
// overflow, duplicate carriers, used_c_i=0 and asynchronous mid-stream reset.
module tb_tone_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        xy_ready;
  logic [7:0]  carrier_num;
  logic [15:0] x;
  logic [15:0] y;
  logic [8:0]  used_c;
  logic        wr_ready;
  logic        overflow;
  logic        valid;
  logic        ifft_ready;
  logic [7:0]  idx;
  logic [15:0] re;
  logic [15:0] im;
  logic        last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ex [256];
  logic [15:0] ey [256];

  tone_buffer #(.CNUMW(8), .CONSTW(16), .NCARR(256)) dut (
    .clk(clk), .reset(reset), .xy_ready_i(xy_ready), .carrier_num_i(carrier_num),
    .x_i(x), .y_i(y), .used_c_i(used_c), .wr_ready_o(wr_ready), .overflow_o(overflow),
    .valid_o(valid), .ifft_ready_i(ifft_ready), .idx_o(idx), .re_o(re), .im_o(im),
    .last_o(last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) begin
      ex[i] = '0;
      ey[i] = '0;
    end
  endtask

  task automatic set_exp(input int c, input logic [15:0] ev_x, input logic [15:0] ev_y);
    ex[c] = ev_x;
    ey[c] = ev_y;
  endtask

  // Called at a negedge; the strobe is sampled at the next posedge.
  task automatic write_xy(input logic [7:0] c, input logic [15:0] vx, input logic [15:0] vy);
    xy_ready    = 1'b1;
    carrier_num = c;
    x           = vx;
    y           = vy;
    @(negedge clk);
    xy_ready    = 1'b0;
  endtask

  task automatic read_symbol(input bit stall);
    int b;
    int cyc;
    int w;
    w = 0;
    while (!valid && w < 8) begin
      @(negedge clk);
      w++;
    end
    check("valid_rise", 32'(valid), 1);
    b   = 0;
    cyc = 0;
    while (b < 256 && cyc < 1200) begin
      ifft_ready = (stall && (cyc % 4 == 1 || cyc % 4 == 2)) ? 1'b0 : 1'b1;
      check("beat_valid", 32'(valid), 1);
      check("beat_idx", 32'(idx), b);
      check("beat_re", 32'(re), 32'(ex[b]));
      check("beat_im", 32'(im), 32'(ey[b]));
      check("beat_last", 32'(last), 32'(b == 255));
      if (ifft_ready) b++;
      cyc++;
      @(negedge clk);
    end
    ifft_ready = 1'b1;
    check("beat_count", b, 256);
    check("gap_valid", 32'(valid), 0);
  endtask

  initial begin
    reset       = 1'b1;
    xy_ready    = 1'b0;
    carrier_num = '0;
    x           = '0;
    y           = '0;
    used_c      = '0;
    ifft_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid), 0);
    check("rst_last", 32'(last), 0);
    check("rst_idx", 32'(idx), 0);
    check("rst_re", 32'(re), 0);
    check("rst_im", 32'(im), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    reset = 1'b0;
    @(negedge clk);

    // Basic fill and readout, with exact write-to-read latency.
    used_c = 9'd3;
    write_xy(8'd5, 16'd10, 16'(-3));
    write_xy(8'd1, 16'd7, 16'd7);
    write_xy(8'd200, 16'(-1), 16'd2);
    check("lat_valid_t1", 32'(valid), 0);
    check("other_bank_free", 32'(wr_ready), 1);
    @(negedge clk);
    check("lat_valid_t2", 32'(valid), 1);
    clear_model();
    set_exp(5, 16'd10, 16'(-3));
    set_exp(1, 16'd7, 16'd7);
    set_exp(200, 16'(-1), 16'd2);
    read_symbol(1'b0);

    // Backpressure with ready pattern 1,0,0,1.
    used_c = 9'd2;
    write_xy(8'd0, 16'd100, 16'd200);
    write_xy(8'd255, 16'(-5), 16'(-6));
    clear_model();
    set_exp(0, 16'd100, 16'd200);
    set_exp(255, 16'(-5), 16'(-6));
    read_symbol(1'b1);

    // Ping-pong fill with the reader stalled, then a dropped third strobe.
    ifft_ready = 1'b0;
    used_c     = 9'd1;
    write_xy(8'd10, 16'd1, 16'd2);
    write_xy(8'd20, 16'd3, 16'd4);
    check("pp_wr_ready", 32'(wr_ready), 0);
    check("pp_ovf_before", 32'(overflow), 0);
    write_xy(8'd30, 16'd5, 16'd6);
    check("pp_ovf_after", 32'(overflow), 1);
    clear_model();
    set_exp(10, 16'd1, 16'd2);
    read_symbol(1'b0);
    check("pp_wr_ready_back", 32'(wr_ready), 1);
    check("pp_ovf_sticky", 32'(overflow), 1);
    clear_model();
    set_exp(20, 16'd3, 16'd4);
    read_symbol(1'b0);

    // Duplicate carrier, mid-symbol used_c_i change, stale flag cleared on reuse.
    used_c = 9'd2;
    write_xy(8'd9, 16'd1, 16'd1);
    used_c = 9'd5;
    write_xy(8'd9, 16'd2, 16'd2);
    clear_model();
    set_exp(9, 16'd2, 16'd2);
    read_symbol(1'b0);
    used_c = 9'd1;
    write_xy(8'd50, 16'd5, 16'd5);
    clear_model();
    set_exp(50, 16'd5, 16'd5);
    read_symbol(1'b0);
    write_xy(8'd3, 16'd3, 16'd3);
    clear_model();
    set_exp(3, 16'd3, 16'd3);
    read_symbol(1'b0);

    // used_c_i = 0 means a full 256-carrier symbol.
    used_c = 9'd0;
    clear_model();
    for (int i = 0; i < 255; i++) begin
      write_xy(8'(i), 16'(i * 3), 16'(-i));
      set_exp(i, 16'(i * 3), 16'(-i));
    end
    @(negedge clk);
    check("u0_not_full", 32'(valid), 0);
    check("u0_wr_ready", 32'(wr_ready), 1);
    write_xy(8'd255, 16'(255 * 3), 16'(-255));
    set_exp(255, 16'(255 * 3), 16'(-255));
    check("u0_lat_t1", 32'(valid), 0);
    @(negedge clk);
    check("u0_lat_t2", 32'(valid), 1);
    for (int b = 0; b < 100; b++) begin
      check("u0_idx", 32'(idx), b);
      check("u0_re", 32'(re), 32'(ex[b]));
      check("u0_im", 32'(im), 32'(ey[b]));
      @(negedge clk);
    end
    check("u0_idx100", 32'(idx), 100);
    check("u0_re100", 32'(re), 32'(ex[100]));

    // Asynchronous reset mid-stream.
    reset = 1'b1;
    #1;
    check("ar_valid", 32'(valid), 0);
    check("ar_idx", 32'(idx), 0);
    check("ar_re", 32'(re), 0);
    check("ar_im", 32'(im), 0);
    check("ar_last", 32'(last), 0);
    check("ar_overflow", 32'(overflow), 0);
    check("ar_wr_ready", 32'(wr_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
